// File: rtl/seq_arm_ctrl.sv
// Arm/confirm activation controller: an `a` edge arms, REQ_PULSES `b` edges switch the
// actuator on, `finished` ends the operation. Covers timeout, max on-time and rearm abort.
`timescale 1ns/1ps
module seq_arm_ctrl #(
  parameter int REQ_PULSES = 3,
  parameter int CNT_W      = 4,
  parameter int TIMEOUT    = 16,
  parameter int MAX_ON     = 0,
  parameter int TW         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             finished,
  output logic             encender,
  output logic             armed,
  output logic [CNT_W-1:0] pulse_count,
  output logic             done,
  output logic             error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    ON    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] REQ_C   = CNT_W'(REQ_PULSES);
  localparam logic [CNT_W-1:0] REQ_M1  = CNT_W'(REQ_PULSES - 1);
  localparam bit               TO_EN   = (TIMEOUT != 0);
  localparam bit               MO_EN   = (MAX_ON != 0);
  localparam logic [TW-1:0]    TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]    MO_LAST = TW'(MAX_ON - 1);

  if (REQ_PULSES < 1 || REQ_PULSES > (2**CNT_W) - 1) begin : g_bad_req
    $error("seq_arm_ctrl: REQ_PULSES must lie in 1..2**CNT_W-1");
  end
  if (TIMEOUT < 0 || TIMEOUT >= 2**TW || MAX_ON < 0 || MAX_ON >= 2**TW) begin : g_bad_tmr
    $error("seq_arm_ctrl: TIMEOUT and MAX_ON must lie in 0..2**TW-1");
  end

  // With a limit disabled the timer keeps counting, so it must stick at full scale.
  function automatic logic [TW-1:0] inc_sat(input logic [TW-1:0] v);
    return (v == {TW{1'b1}}) ? v : v + TW'(1);
  endfunction

  state_t        state;
  logic          a_q;
  logic          b_q;
  logic [TW-1:0] timer;
  logic          rise_a;
  logic          rise_b;
  logic          last_pulse;

  // Edge-detect stage: compare the current level with the level seen last edge.
  assign rise_a     = a & ~a_q;
  assign rise_b     = b & ~b_q;
  assign last_pulse = (pulse_count == REQ_M1);

  // Control stage: state and every output update together on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= a;
      b_q         <= b;
      encender    <= 1'b0;
      armed       <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      pulse_count <= '0;
      timer       <= '0;
    end else begin
      a_q   <= a;
      b_q   <= b;
      done  <= 1'b0;
      error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise_a) begin
            state       <= ARMED;
            armed       <= 1'b1;
            pulse_count <= '0;
            timer       <= '0;
          end
        end
        ARMED: begin
          if (rise_a) begin
            state       <= IDLE;
            armed       <= 1'b0;
            error       <= 1'b1;
            pulse_count <= '0;
            timer       <= '0;
          end else if (rise_b && last_pulse) begin
            state       <= ON;
            armed       <= 1'b0;
            encender    <= 1'b1;
            pulse_count <= REQ_C;
            timer       <= '0;
          end else if (rise_b) begin
            pulse_count <= pulse_count + CNT_W'(1);
            timer       <= '0;
          end else if (TO_EN && timer == TO_LAST) begin
            state       <= IDLE;
            armed       <= 1'b0;
            error       <= 1'b1;
            pulse_count <= '0;
            timer       <= '0;
          end else begin
            timer <= inc_sat(timer);
          end
        end
        ON: begin
          // finished is tested first so that it beats a coincident on-time expiry.
          if (finished) begin
            state       <= IDLE;
            encender    <= 1'b0;
            done        <= 1'b1;
            pulse_count <= '0;
            timer       <= '0;
          end else if (MO_EN && timer == MO_LAST) begin
            state       <= IDLE;
            encender    <= 1'b0;
            error       <= 1'b1;
            pulse_count <= '0;
            timer       <= '0;
          end else begin
            timer <= inc_sat(timer);
          end
        end
        default: begin
          state       <= IDLE;
          encender    <= 1'b0;
          armed       <= 1'b0;
          pulse_count <= '0;
          timer       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_arm_ctrl.sv
// Scoreboard bench for seq_arm_ctrl: three parameter sets, expected output tuples queued
// with their edge number, checked by an independent monitor on every output change.
`timescale 1ns/1ps
module tb_seq_arm_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst, a, b, fin;
  logic [2:0] enc, arm, dn, er;
  logic [3:0] pc0, pc1;
  logic [2:0] pc2;

  seq_arm_ctrl u0 (
    .clk(clk), .rst(rst[0]), .a(a[0]), .b(b[0]), .finished(fin[0]),
    .encender(enc[0]), .armed(arm[0]), .pulse_count(pc0), .done(dn[0]), .error(er[0])
  );
  seq_arm_ctrl #(.REQ_PULSES(1), .MAX_ON(10)) u1 (
    .clk(clk), .rst(rst[1]), .a(a[1]), .b(b[1]), .finished(fin[1]),
    .encender(enc[1]), .armed(arm[1]), .pulse_count(pc1), .done(dn[1]), .error(er[1])
  );
  seq_arm_ctrl #(.REQ_PULSES(5), .CNT_W(3)) u2 (
    .clk(clk), .rst(rst[2]), .a(a[2]), .b(b[2]), .finished(fin[2]),
    .encender(enc[2]), .armed(arm[2]), .pulse_count(pc2), .done(dn[2]), .error(er[2])
  );

  // Output tuple: {encender, armed, done, error, pulse_count[3:0]}
  logic [7:0] obs [3];
  assign obs[0] = {enc[0], arm[0], dn[0], er[0], pc0};
  assign obs[1] = {enc[1], arm[1], dn[1], er[1], pc1};
  assign obs[2] = {enc[2], arm[2], dn[2], er[2], 1'b0, pc2};

  typedef struct {
    int         id;
    int         edge_n;
    logic [7:0] v;
    string      tag;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic [7:0] prev [3];
  logic [2:0] seen;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pk(bit e, bit ar, int pc, bit d, bit x);
    return {e, ar, d, x, 4'(pc)};
  endfunction

  task automatic push_exp(input int id, input int e, input logic [7:0] v, input string tag);
    exp_t t;
    t.id = id; t.edge_n = e; t.v = v; t.tag = tag;
    q.push_back(t);
  endtask

  // Monitor: entries due this edge are compared; any other output change is unexpected.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      seen = '0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].edge_n == cyc) begin
          checks++;
          if (obs[q[i].id] !== q[i].v) begin
            errors++;
            $display("FAIL %s u%0d edge %0d got %h want %h", q[i].tag, q[i].id, cyc, obs[q[i].id], q[i].v);
          end
          seen[q[i].id] = 1'b1;
          q.delete(i);
        end else if (q[i].edge_n < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s u%0d stale at edge %0d got %h want %h", q[i].tag, q[i].id, cyc, obs[q[i].id], q[i].v);
          q.delete(i);
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (obs[k] !== prev[k] && !seen[k]) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change u%0d edge %0d got %h want %h", k, cyc, obs[k], prev[k]);
        end
        prev[k] = obs[k];
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) step();
  endtask

  task automatic pa(input int id);
    a[id] = 1'b1; step(); step();
    a[id] = 1'b0; step(); step();
  endtask

  task automatic pb(input int id);
    b[id] = 1'b1; step(); step();
    b[id] = 1'b0; step(); step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int eb, eon;
    rst = 3'b111; a = 3'b010; b = '0; fin = '0;
    step(); step();
    rst = '0;
    for (int k = 0; k < 3; k++) prev[k] = obs[k];
    mon_en = 1'b1;
    for (int k = 0; k < 3; k++) push_exp(k, 3, pk(0, 0, 0, 0, 0), "reset_state");
    push_exp(1, 5, pk(0, 0, 0, 0, 0), "a_held_no_arm");
    step(); step(); step();
    a[1] = 1'b0;
    step();

    // Normal three-pulse sequence on the default instance
    push_exp(0, cyc + 1, pk(0, 1, 0, 0, 0), "t1_arm");  pa(0);
    push_exp(0, cyc + 1, pk(0, 1, 1, 0, 0), "t1_pc1");  pb(0);
    push_exp(0, cyc + 1, pk(0, 1, 2, 0, 0), "t1_pc2");  pb(0);
    push_exp(0, cyc + 1, pk(1, 0, 3, 0, 0), "t1_on");   pb(0);
    fin[0] = 1'b1;
    push_exp(0, cyc + 1, pk(0, 0, 0, 1, 0), "t1_done");
    push_exp(0, cyc + 2, pk(0, 0, 0, 0, 0), "t1_done_clr");
    step(); step(); fin[0] = 1'b0; step(); step();

    // Rearm abort, then finished in IDLE must not give done
    push_exp(0, cyc + 1, pk(0, 1, 0, 0, 0), "t2_arm");  pa(0);
    push_exp(0, cyc + 1, pk(0, 1, 1, 0, 0), "t2_pc1");  pb(0);
    push_exp(0, cyc + 1, pk(0, 1, 2, 0, 0), "t2_pc2");  pb(0);
    push_exp(0, cyc + 1, pk(0, 0, 0, 0, 1), "t2_rearm_err");
    push_exp(0, cyc + 2, pk(0, 0, 0, 0, 0), "t2_idle");
    pa(0);
    fin[0] = 1'b1;
    push_exp(0, cyc + 2, pk(0, 0, 0, 0, 0), "t2_no_done");
    step(); step(); fin[0] = 1'b0; step();

    // Timeout 16 cycles after the accepted b edge
    push_exp(0, cyc + 1, pk(0, 1, 0, 0, 0), "t3_arm");  pa(0);
    eb = cyc + 1;
    push_exp(0, eb,      pk(0, 1, 1, 0, 0), "t3_pc1");
    push_exp(0, eb + 15, pk(0, 1, 1, 0, 0), "t3_pre_timeout");
    push_exp(0, eb + 16, pk(0, 0, 0, 0, 1), "t3_timeout");
    push_exp(0, eb + 17, pk(0, 0, 0, 0, 0), "t3_timeout_clr");
    pb(0);
    wait_until(eb + 18);

    // A b edge at cycle 15 restarts the timer
    push_exp(0, cyc + 1, pk(0, 1, 0, 0, 0), "t3b_arm");  pa(0);
    eb = cyc + 1;
    push_exp(0, eb, pk(0, 1, 1, 0, 0), "t3b_pc1");
    pb(0);
    wait_until(eb + 14);
    push_exp(0, eb + 15, pk(0, 1, 2, 0, 0), "t3b_pc2_at15");
    push_exp(0, eb + 16, pk(0, 1, 2, 0, 0), "t3b_no_timeout");
    pb(0);
    push_exp(0, cyc + 1, pk(0, 0, 0, 0, 1), "t3b_abort");
    push_exp(0, cyc + 2, pk(0, 0, 0, 0, 0), "t3b_abort_clr");
    pa(0);

    // Simultaneous a/b edges arm only; a long b counts once
    a[0] = 1'b1; b[0] = 1'b1;
    push_exp(0, cyc + 1, pk(0, 1, 0, 0, 0), "t5_sim_arm_pc0");
    step(); step();
    a[0] = 1'b0; b[0] = 1'b0;
    step(); step();
    b[0] = 1'b1;
    eb = cyc + 1;
    push_exp(0, eb,     pk(0, 1, 1, 0, 0), "t5_held_first");
    push_exp(0, eb + 4, pk(0, 1, 1, 0, 0), "t5_held_once");
    repeat (5) step();
    b[0] = 1'b0; step();
    push_exp(0, cyc + 1, pk(0, 0, 0, 0, 1), "t5_abort");
    push_exp(0, cyc + 2, pk(0, 0, 0, 0, 0), "t5_abort_clr");
    pa(0);

    // MAX_ON = 10 expiry, REQ_PULSES = 1
    push_exp(1, cyc + 1, pk(0, 1, 0, 0, 0), "t4_arm");  pa(1);
    eon = cyc + 1;
    push_exp(1, eon,      pk(1, 0, 1, 0, 0), "t4_on");
    push_exp(1, eon + 9,  pk(1, 0, 1, 0, 0), "t4_on_last");
    push_exp(1, eon + 10, pk(0, 0, 0, 0, 1), "t4_maxon_err");
    push_exp(1, eon + 11, pk(0, 0, 0, 0, 0), "t4_maxon_clr");
    pb(1);
    wait_until(eon + 12);

    // finished coinciding with MAX_ON expiry gives done only
    push_exp(1, cyc + 1, pk(0, 1, 0, 0, 0), "t4b_arm");  pa(1);
    eon = cyc + 1;
    push_exp(1, eon,      pk(1, 0, 1, 0, 0), "t4b_on");
    push_exp(1, eon + 10, pk(0, 0, 0, 1, 0), "t4b_done_wins");
    push_exp(1, eon + 11, pk(0, 0, 0, 0, 0), "t4b_done_clr");
    pb(1);
    wait_until(eon + 9);
    fin[1] = 1'b1; step(); fin[1] = 1'b0; step(); step();

    // Reset in ON
    push_exp(0, cyc + 1, pk(0, 1, 0, 0, 0), "t6_arm");  pa(0);
    push_exp(0, cyc + 1, pk(0, 1, 1, 0, 0), "t6_pc1");  pb(0);
    push_exp(0, cyc + 1, pk(0, 1, 2, 0, 0), "t6_pc2");  pb(0);
    push_exp(0, cyc + 1, pk(1, 0, 3, 0, 0), "t6_on");   pb(0);
    rst[0] = 1'b1;
    push_exp(0, cyc + 1, pk(0, 0, 0, 0, 0), "t6_rst_in_on");
    step(); rst[0] = 1'b0; step();

    // Five-pulse sequence with a 3-bit counter
    push_exp(2, cyc + 1, pk(0, 1, 0, 0, 0), "t6b_arm");  pa(2);
    for (int p = 1; p <= 4; p++) begin
      push_exp(2, cyc + 1, pk(0, 1, p, 0, 0), "t6b_pc");
      pb(2);
    end
    push_exp(2, cyc + 1, pk(1, 0, 5, 0, 0), "t6b_on");  pb(2);
    fin[2] = 1'b1;
    push_exp(2, cyc + 1, pk(0, 0, 0, 1, 0), "t6b_done");
    push_exp(2, cyc + 2, pk(0, 0, 0, 0, 0), "t6b_done_clr");
    step(); fin[2] = 1'b0; step();

    repeat (4) step();
    while (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s u%0d never checked (due edge %0d) got %h want %h",
               q[0].tag, q[0].id, q[0].edge_n, obs[q[0].id], q[0].v);
      q.delete(0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_arm_ctrl.md
Name: seq_arm_ctrl

Overview:
- Parametrised arm/confirm activation controller; successor to the single-sequence Quiz3 controller.
- Sequence: operator pulses `a` to arm, then gives REQ_PULSES rising edges on `b` to confirm. Block then drives `encender` until `finished`.
- Adds over the previous generation: configurable pulse count, inactivity timeout, max on-time, abort-on-rearm, and status/error outputs.
- Sits between debounced operator inputs and the actuator enable.

Parameters:
- REQ_PULSES, 3: number of `b` rising edges required in ARMED to switch on; legal range 1..2**CNT_W-1.
- CNT_W, 4: width of the pulse counter and of `pulse_count`.
- TIMEOUT, 16: max clock cycles in ARMED without a `b` rising edge before abort; 0 disables.
- MAX_ON, 0: max clock cycles in ON before forced shutdown; 0 means unlimited.
- TW, 16: width of the shared cycle timer; TIMEOUT and MAX_ON must be < 2**TW.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- a  in  1  arm request (level, already synchronous and debounced).
- b  in  1  confirm pulse (level, already synchronous and debounced).
- finished  in  1  end-of-operation from the actuator (level).
- encender  out  1  actuator enable; high exactly while state == ON.
- armed  out  1  high while state == ARMED.
- pulse_count  out  CNT_W  number of `b` rising edges accepted in the current ARMED episode.
- done  out  1  one-cycle pulse on normal completion.
- error  out  1  one-cycle pulse on abort (rearm, timeout or MAX_ON).

Behaviour:
- Edge detect: registers `a_q` and `b_q`; rise_a = a & ~a_q, rise_b = b & ~b_q. All inputs are sampled at the rising edge of `clk`.
- Reset (rst = 1 at an edge): state = IDLE; encender, armed, done, error = 0; pulse_count = 0; timer = 0.
  - During reset, `a_q` and `b_q` load the current `a` and `b`. An input held high across reset release therefore does not produce an edge.
  - Reset overrides every transition, including in ON (encender drops the edge after rst is sampled).
- States: IDLE, ARMED, ON. All outputs are registered and change at the same edge as the state.
- IDLE:
  - rise_a -> ARMED, with pulse_count = 0 and timer = 0.
  - `b` and `finished` are ignored.
  - Simultaneous rise_a and rise_b: arm only; that `b` edge is not counted.
- ARMED (checked in this priority order):
  1. rise_a -> IDLE, error pulse, pulse_count = 0.
  2. rise_b with pulse_count + 1 == REQ_PULSES -> ON, pulse_count = REQ_PULSES, timer = 0.
  3. rise_b otherwise -> pulse_count + 1, timer = 0.
  4. TIMEOUT != 0 and timer == TIMEOUT - 1 with no rise_b -> IDLE, error pulse, pulse_count = 0.
  5. Otherwise timer + 1.
  - `finished` is ignored in ARMED.
- ON:
  - encender = 1; pulse_count holds REQ_PULSES.
  - finished = 1 -> IDLE, done pulse, pulse_count = 0.
  - Otherwise, if MAX_ON != 0 and timer == MAX_ON - 1 -> IDLE, error pulse.
  - Otherwise timer + 1.
  - finished and MAX_ON expiry in the same cycle: done wins, no error.
  - `a` and `b` are ignored in ON.
- Latency:
  - rise_a sampled at edge k -> armed = 1 after edge k.
  - Final rise_b sampled at edge k -> encender = 1 after edge k.
  - finished sampled at edge k -> encender = 0 and done = 1 after edge k; done = 0 after edge k+1.
- done and error are never high in the same cycle and are never high for two consecutive cycles.
- Counter never wraps; REQ_PULSES ≤ 2**CNT_W - 1 is checked by an elaboration assertion.

Test Plan:
1. Defaults. Reset 2 cycles; a high 2 cycles; then 3 `b` pulses (each 2 high / 2 low) -> armed 1 after the a edge; pulse_count 1, 2, then encender 1 after the third b edge. finished high 2 cycles -> encender 0 and done = 1 for 1 cycle.
2. Rearm abort. Arm, 2 `b` pulses, then `a` pulse -> error = 1 for 1 cycle, state IDLE, pulse_count 0, encender never 1. A subsequent finished pulse produces no done.
3. Timeout (TIMEOUT = 16). Arm, 1 `b` pulse, then idle inputs -> error exactly 16 cycles after the accepted b edge, armed 0. A `b` edge at cycle 15 instead resets the timer and there is no error.
4. MAX_ON = 10, REQ_PULSES = 1. Arm, 1 `b` pulse, no finished -> encender high exactly 10 cycles, then error pulse. finished in cycle 10 -> done instead of error.
5. Edge cases:
   - `a` held high through reset release -> no arm.
   - rise_a and rise_b in the same cycle in IDLE -> armed with pulse_count 0.
   - `b` held high 5 cycles -> counts once.
6. Reset mid-ON. Reach ON, assert rst for 1 cycle -> all outputs 0 after that edge. Then a normal sequence succeeds with REQ_PULSES = 5, CNT_W = 3.
